// File: rtl/reset_seq_pkg.sv
// Shared encodings for the reset sequencer: FSM states,
// reason bit positions and a small sizing helper.
package reset_seq_pkg;

  localparam logic [2:0] S_HOLD      = 3'd0;
  localparam logic [2:0] S_WAIT_LOW  = 3'd1;
  localparam logic [2:0] S_RELEASE   = 3'd2;
  localparam logic [2:0] S_WAIT_HIGH = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  typedef enum logic [2:0] {
    ST_HOLD      = S_HOLD,
    ST_WAIT_LOW  = S_WAIT_LOW,
    ST_RELEASE   = S_RELEASE,
    ST_WAIT_HIGH = S_WAIT_HIGH,
    ST_RUN       = S_RUN
  } state_t;

  localparam int REASON_POR  = 0;
  localparam int REASON_SW   = 1;
  localparam int REASON_WDOG = 2;

  function automatic int max_int(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_ack_sync.sv
// Per-bit 2-flop synchroniser for the domain reset feedback.
// Resets high so a stale "deasserted" ack is seen until real data lands.
module reset_seq_ack_sync #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n_in_fp,
  input  logic [N-1:0] dom_ack_n,
  output logic [N-1:0] ack_s
);

  // False-path anchor: async timing exceptions key on this net.
  logic [N-1:0] ack_fp;
  logic [N-1:0] ack_meta;

  assign ack_fp = dom_ack_n;

  always_ff @(posedge clk or negedge rst_n_in_fp) begin
    if (!rst_n_in_fp) begin
      ack_meta <= '1;
      ack_s    <= '1;
    end else begin
      ack_meta <= ack_fp;
      ack_s    <= ack_meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Always-on reset sequencer: holds all domain resets, then releases
// them in index order, gated on each domain's synchronised feedback.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS   = 3,
  parameter int MIN_ASSERT  = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n_in_fp,
  input  logic                 req_sw,
  input  logic                 req_wdog,
  input  logic [N_DOMAINS-1:0] dom_ack_n,
  input  logic                 reason_clr,
  output logic [N_DOMAINS-1:0] dom_rst_n,
  output logic                 sys_run,
  output logic [2:0]           reason,
  output logic                 ack_timeout
);

  localparam int CNT_MAX = max_int(MIN_ASSERT, ACK_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       idx_d;
  logic [N_DOMAINS-1:0]   dom_d;
  logic [N_DOMAINS-1:0]   ack_s;
  logic                   run_d;
  logic [2:0]             reason_d;
  logic [2:0]             req_bits;
  logic                   tmo_d;
  logic                   tmo_evt;
  logic                   req;

  reset_seq_ack_sync #(
    .N (N_DOMAINS)
  ) u_ack_sync (
    .clk         (clk),
    .rst_n_in_fp (rst_n_in_fp),
    .dom_ack_n   (dom_ack_n),
    .ack_s       (ack_s)
  );

  assign req = req_sw | req_wdog;

  // Counter saturates instead of wrapping.
  assign cnt_inc = (cnt_q == CNT_SAT) ?
                   cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    idx_d   = idx_q;
    tmo_evt = 1'b0;
    unique case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (ack_s == '0 || cnt_q == ACK_LAST) begin
          tmo_evt = |ack_s;
          state_d = ST_RELEASE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        state_d = ST_WAIT_HIGH;
        cnt_d   = '0;
      end
      ST_WAIT_HIGH: begin
        if (ack_s[idx_q] || cnt_q == ACK_LAST) begin
          tmo_evt = !ack_s[idx_q];
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RELEASE;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
    // A request restarts the whole sequence from any state.
    if (req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      tmo_evt = 1'b0;
    end
  end

  // Outputs are registered from the next state, so a released
  // domain rises on the same edge the FSM enters RELEASE.
  always_comb begin
    dom_d = dom_rst_n;
    unique case (state_d)
      ST_HOLD:    dom_d = '0;
      ST_RELEASE: dom_d = dom_rst_n |
                          (N_DOMAINS'(1) << idx_d);
      ST_RUN:     dom_d = '1;
      default:    dom_d = dom_rst_n;
    endcase
    run_d = (state_d == ST_RUN);
  end

  always_comb begin
    req_bits              = '0;
    req_bits[REASON_SW]   = req_sw;
    req_bits[REASON_WDOG] = req_wdog;
    reason_d = reason_clr ? 3'b000 : reason;
    if (req) begin
      reason_d             = reason_d | req_bits;
      reason_d[REASON_POR] = 1'b0;
    end
    tmo_d = reason_clr ? 1'b0 : ack_timeout;
    if (tmo_evt) begin
      tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n_in_fp) begin
    if (!rst_n_in_fp) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      dom_rst_n   <= '0;
      sys_run     <= 1'b0;
      reason      <= 3'b001;
      ack_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dom_rst_n   <= dom_d;
      sys_run     <= run_d;
      reason      <= reason_d;
      ack_timeout <= tmo_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised bench for reset_sequencer: a delay-line domain model
// feeds back acks; release times come from an arithmetic model.
module tb_reset_sequencer;

  localparam int N   = 3;
  localparam int MIN = 16;
  localparam int TO  = 255;

  logic         clk = 1'b0;
  logic         rst_n_in_fp = 1'b0;
  logic         req_sw = 1'b0;
  logic         req_wdog = 1'b0;
  logic         reason_clr = 1'b0;
  logic [N-1:0] dom_ack_n;
  logic [N-1:0] dom_rst_n;
  logic         sys_run;
  logic [2:0]   reason;
  logic         ack_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int d_lat = 3;
  logic [N-1:0] stuck = '0;
  logic [N-1:0] pipe [8];
  int rise_t [N];
  int rise_n [N];
  int run_t;
  logic [N-1:0] prev_dom = '0;
  logic prev_run = 1'b0;
  logic [2:0] exp_reason;

  reset_sequencer #(
    .N_DOMAINS   (N),
    .MIN_ASSERT  (MIN),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n_in_fp (rst_n_in_fp),
    .req_sw      (req_sw),
    .req_wdog    (req_wdog),
    .dom_ack_n   (dom_ack_n),
    .reason_clr  (reason_clr),
    .dom_rst_n   (dom_rst_n),
    .sys_run     (sys_run),
    .reason      (reason),
    .ack_timeout (ack_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Each domain's synchroniser reports its reset d_lat edges later.
  always @(posedge clk) begin
    pipe[0] <= dom_rst_n;
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end

  assign dom_ack_n = pipe[3'(d_lat - 1)] & ~stuck;

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (dom_rst_n[k] && !prev_dom[k]) begin
        rise_t[k] = cyc;
        rise_n[k]++;
      end
    end
    if (sys_run && !prev_run) run_t = cyc;
    prev_dom = dom_rst_n;
    prev_run = sys_run;
  end

  // Edge on which domain k rises (k == N gives sys_run), counted
  // from the last edge r that (re)entered HOLD.
  function automatic int exp_edge(
    input int r, input int d,
    input logic [N-1:0] stk, input int k
  );
    int t;
    t = r + MIN + 1;
    for (int j = 0; j < k; j++)
      t += stk[j] ? TO + 1 : d + 3;
    return t;
  endfunction

  task automatic clear_mon();
    for (int k = 0; k < N; k++) begin
      rise_t[k] = -1;
      rise_n[k] = 0;
    end
    run_t = -1;
  endtask

  task automatic do_por(output int r);
    @(negedge clk);
    rst_n_in_fp = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    clear_mon();
    rst_n_in_fp = 1'b1;
    r = cyc;
  endtask

  task automatic pulse(input bit wd, input bit clr,
                       output int r);
    @(negedge clk);
    #1;
    clear_mon();
    req_sw     = !wd;
    req_wdog   = wd;
    reason_clr = clr;
    @(posedge clk);
    #1;
    req_sw     = 1'b0;
    req_wdog   = 1'b0;
    reason_clr = 1'b0;
    r = cyc;
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sys_run) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic wait_dom(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dom_rst_n[k]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int r; bit ok; int d;
    d = $urandom_range(1, 4);
    d_lat = d;
    stuck = '0;
    do_por(r);
    checks++;
    if ({dom_rst_n, sys_run} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_outs got %b/%b exp 000/0",
               dom_rst_n, sys_run);
    end
    checks++;
    if ({reason, ack_timeout} !== 4'b0010) begin
      errors++;
      $display("FAIL rst_reason got %b/%b exp 001/0",
               reason, ack_timeout);
    end
    wait_run(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL por_run got 0 exp 1");
    end
    for (int k = 0; k <= N; k++) begin
      int got;
      got = (k == N) ? run_t : rise_t[k];
      checks++;
      if (got !== exp_edge(r, d, stuck, k) ||
          (k < N && rise_n[k] !== 1)) begin
        errors++;
        $display("FAIL por_edge%0d got %0d exp %0d (d=%0d)",
                 k, got - r, exp_edge(r, d, stuck, k) - r, d);
      end
    end
    checks++;
    if ({dom_rst_n, reason, ack_timeout} !== 7'b111_001_0) begin
      errors++;
      $display("FAIL por_end got %b/%b/%b exp 111/001/0",
               dom_rst_n, reason, ack_timeout);
    end
  endtask

  task automatic test_sw_in_run();
    int r; bit ok;
    pulse(1'b0, 1'b0, r);
    checks++;
    if ({dom_rst_n, sys_run, reason} !== 7'b000_0_010) begin
      errors++;
      $display("FAIL sw_edge got %b/%b/%b exp 000/0/010",
               dom_rst_n, sys_run, reason);
    end
    wait_run(ok);
    for (int k = 0; k <= N; k++) begin
      int got;
      got = (k == N) ? run_t : rise_t[k];
      checks++;
      if (!ok || got !== exp_edge(r, d_lat, '0, k) ||
          (k < N && rise_n[k] !== 1)) begin
        errors++;
        $display("FAIL sw_edge%0d got %0d exp %0d",
                 k, got - r, exp_edge(r, d_lat, '0, k) - r);
      end
    end
  endtask

  task automatic test_wdog_wait_high();
    int r; int len; bit ok;
    do_por(r);
    wait_dom(1, ok);
    @(negedge clk);
    #1;
    checks++;
    if (!ok || dom_rst_n !== 3'b011) begin
      errors++;
      $display("FAIL wd_pre got %b exp 011", dom_rst_n);
    end
    len = $urandom_range(1, 4);
    clear_mon();
    req_wdog = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dom_rst_n !== 3'b000 || sys_run !== 1'b0) begin
      errors++;
      $display("FAIL wd_edge got %b/%b exp 000/0",
               dom_rst_n, sys_run);
    end
    repeat (len - 1) @(posedge clk);
    #1;
    req_wdog = 1'b0;
    r = cyc;
    checks++;
    if (reason !== 3'b100) begin
      errors++;
      $display("FAIL wd_reason got %b exp 100", reason);
    end
    wait_run(ok);
    for (int k = 0; k <= N; k++) begin
      int got;
      got = (k == N) ? run_t : rise_t[k];
      checks++;
      if (!ok || got !== exp_edge(r, d_lat, '0, k) ||
          (k < N && rise_n[k] !== 1)) begin
        errors++;
        $display("FAIL wd_edge%0d got %0d exp %0d (len=%0d)",
                 k, got - r, exp_edge(r, d_lat, '0, k) - r, len);
      end
    end
  endtask

  task automatic test_ack_timeout();
    int r; bit ok;
    stuck = 3'b010;
    do_por(r);
    wait_dom(1, ok);
    #1;
    checks++;
    if (!ok || ack_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_pre got ok=%0b tmo=%b exp 1/0",
               ok, ack_timeout);
    end
    wait_run(ok);
    for (int k = 0; k <= N; k++) begin
      int got;
      got = (k == N) ? run_t : rise_t[k];
      checks++;
      if (!ok || got !== exp_edge(r, d_lat, stuck, k)) begin
        errors++;
        $display("FAIL to_edge%0d got %0d exp %0d",
                 k, got - r, exp_edge(r, d_lat, stuck, k) - r);
      end
    end
    checks++;
    if ({ack_timeout, reason} !== 4'b1_001) begin
      errors++;
      $display("FAIL to_flag got %b/%b exp 1/001",
               ack_timeout, reason);
    end
    stuck = '0;
  endtask

  task automatic test_clr_and_req();
    int r; bit ok;
    pulse(1'b1, 1'b0, r);
    checks++;
    if ({reason, ack_timeout} !== 4'b100_1) begin
      errors++;
      $display("FAIL cr_wd got %b/%b exp 100/1",
               reason, ack_timeout);
    end
    wait_run(ok);
    pulse(1'b0, 1'b1, r);
    checks++;
    if ({reason, ack_timeout} !== 4'b010_0) begin
      errors++;
      $display("FAIL cr_both got %b/%b exp 010/0",
               reason, ack_timeout);
    end
    wait_run(ok);
    checks++;
    if (!ok || run_t !== exp_edge(r, d_lat, '0, N)) begin
      errors++;
      $display("FAIL cr_run got %0d exp %0d",
               run_t - r, exp_edge(r, d_lat, '0, N) - r);
    end
    @(negedge clk);
    reason_clr = 1'b1;
    @(posedge clk);
    #1;
    reason_clr = 1'b0;
    checks++;
    if ({reason, sys_run, dom_rst_n} !== 7'b000_1_111) begin
      errors++;
      $display("FAIL cr_lone got %b/%b/%b exp 000/1/111",
               reason, sys_run, dom_rst_n);
    end
  endtask

  task automatic test_async_reset();
    int r; bit ok;
    pulse(1'b0, 1'b0, r);
    wait_dom(0, ok);
    #2;
    rst_n_in_fp = 1'b0;
    #1;
    checks++;
    if (!ok || {dom_rst_n, sys_run} !== 4'b0000) begin
      errors++;
      $display("FAIL ar_outs got %b/%b exp 000/0",
               dom_rst_n, sys_run);
    end
    checks++;
    if ({reason, ack_timeout} !== 4'b001_0) begin
      errors++;
      $display("FAIL ar_reason got %b/%b exp 001/0",
               reason, ack_timeout);
    end
    repeat (2) @(negedge clk);
    #1;
    clear_mon();
    rst_n_in_fp = 1'b1;
    r = cyc;
    wait_run(ok);
    for (int k = 0; k <= N; k++) begin
      int got;
      got = (k == N) ? run_t : rise_t[k];
      checks++;
      if (!ok || got !== exp_edge(r, d_lat, '0, k) ||
          (k < N && rise_n[k] !== 1)) begin
        errors++;
        $display("FAIL ar_edge%0d got %0d exp %0d",
                 k, got - r, exp_edge(r, d_lat, '0, k) - r);
      end
    end
  endtask

  task automatic test_back_to_back();
    int r; int gap; bit ok; bit wd;
    exp_reason = reason;
    for (int it = 0; it < 5; it++) begin
      d_lat = $urandom_range(1, 4);
      repeat (10) @(negedge clk);
      wd = 1'($urandom_range(0, 1));
      pulse(wd, 1'b0, r);
      exp_reason = (exp_reason | (wd ? 3'b100 : 3'b010)) & 3'b110;
      gap = $urandom_range(0, 40);
      repeat (gap) @(negedge clk);
      wd = 1'($urandom_range(0, 1));
      pulse(wd, 1'b0, r);
      exp_reason = (exp_reason | (wd ? 3'b100 : 3'b010)) & 3'b110;
      wait_run(ok);
      for (int k = 0; k <= N; k++) begin
        int got;
        got = (k == N) ? run_t : rise_t[k];
        checks++;
        if (!ok || got !== exp_edge(r, d_lat, '0, k) ||
            (k < N && rise_n[k] !== 1)) begin
          errors++;
          $display("FAIL b2b%0d_edge%0d got %0d exp %0d gap=%0d",
                   it, k, got - r,
                   exp_edge(r, d_lat, '0, k) - r, gap);
        end
      end
      checks++;
      if (reason !== exp_reason) begin
        errors++;
        $display("FAIL b2b%0d_reason got %b exp %b",
                 it, reason, exp_reason);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_in_run();
    test_wdog_wait_high();
    test_ack_timeout();
    test_clr_and_req();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
